uart_transmitter: RTL and testbench

Buffered 8N1 UART transmitter, the transmit-side counterpart of the UART receive path fed by the 115200 Hz sample clock in the clock generator. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them LSB-first on `uart_tx` at a fixed clocks-per-bit ratio derived from `clock_144mhz`. Used for status and acknowledge traffic back to the host controlling the LED actor.

---
 rtl/uart_transmitter_if.sv | 18 +
 rtl/uart_transmitter.sv | 155 +++++++++++++++
 tb/tb_uart_transmitter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Byte write handshake into the UART transmitter FIFO.
interface uart_transmitter_if;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready;

   modport master (
      output data,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding an LSB-first serialiser.
module uart_transmitter #(
   parameter int unsigned CLOCKS_PER_BIT = 1250,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned STOP_BITS      = 1
) (
   input  logic                        clock_144mhz,
   input  logic                        reset,
   uart_transmitter_if.slave           in_if,
   output logic                        uart_tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(CLOCKS_PER_BIT);
   localparam logic [CntW-1:0] BaudMax = CntW'(CLOCKS_PER_BIT - 1);
   localparam logic [PtrW:0]   Full    = (PtrW + 1)'(FIFO_DEPTH);
   localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q;
   logic [CntW-1:0] baud_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic            tx_q;
   logic            busy_q, busy_d;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   count_q, count_d;

   logic push, pop, baud_wrap, stop_done;

   // Ready depends on registered count only, never on data_valid.
   assign in_if.data_ready = (count_q != Full);

   // Handshake, pop and next-count decode.
   always_comb begin
      baud_wrap = (baud_q == BaudMax);
      stop_done = (state_q == StStop) && baud_wrap && (bit_idx_q == StopLast);
      push      = in_if.data_valid && in_if.data_ready;
      pop       = (count_q != '0) && ((state_q == StIdle) || stop_done);
      count_d   = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
      // Next state is non-idle unless we are leaving STOP/IDLE without a pop.
      busy_d = ((state_q != StIdle) && !stop_done) || pop || (count_d != '0);
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clock_144mhz) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_if.data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock_144mhz or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Registered busy flag, reflecting state and occupancy after this edge.
   always_ff @(posedge clock_144mhz or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Frame FSM; tx_q is loaded with the line level of the state being entered.
   always_ff @(posedge clock_144mhz or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (baud_wrap) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  state_q   <= StData;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            StData: begin
               if (baud_wrap) begin
                  baud_q    <= '0;
                  shift_q   <= {1'b0, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 1'b1;
                  if (bit_idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     tx_q <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            StStop: begin
               if (baud_wrap) begin
                  baud_q <= '0;
                  if (bit_idx_q == StopLast) begin
                     bit_idx_q <= '0;
                     if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= StIdle;
                     end
                  end else begin
                     // Counts stop bits when STOP_BITS is 2.
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign uart_tx    = tx_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter: default, mid-speed and fast instances.
module tb_uart_transmitter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   logic tx_a, tx_b, tx_c;
   logic busy_a, busy_b, busy_c;
   logic [2:0] cnt_a, cnt_b, cnt_c;

   int checks   = 0;
   int failures = 0;

   uart_transmitter_if if_a ();
   uart_transmitter_if if_b ();
   uart_transmitter_if if_c ();

   uart_transmitter #(.CLOCKS_PER_BIT(1250), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
      .clock_144mhz(clk), .reset(rst_a), .in_if(if_a),
      .uart_tx(tx_a), .busy(busy_a), .fifo_count(cnt_a)
   );
   uart_transmitter #(.CLOCKS_PER_BIT(16), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_b (
      .clock_144mhz(clk), .reset(rst_b), .in_if(if_b),
      .uart_tx(tx_b), .busy(busy_b), .fifo_count(cnt_b)
   );
   uart_transmitter #(.CLOCKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_c (
      .clock_144mhz(clk), .reset(rst_c), .in_if(if_c),
      .uart_tx(tx_c), .busy(busy_c), .fifo_count(cnt_c)
   );

   function automatic logic tx_of(int w);
      case (w)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic logic busy_of(int w);
      case (w)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic rdy_of(int w);
      case (w)
         0:       return if_a.data_ready;
         1:       return if_b.data_ready;
         default: return if_c.data_ready;
      endcase
   endfunction

   function automatic logic [2:0] cnt_of(int w);
      case (w)
         0:       return cnt_a;
         1:       return cnt_b;
         default: return cnt_c;
      endcase
   endfunction

   task automatic drive(input int w, input logic v, input logic [7:0] d);
      case (w)
         0:       begin if_a.data_valid = v; if_a.data = d; end
         1:       begin if_b.data_valid = v; if_b.data = d; end
         default: begin if_c.data_valid = v; if_c.data = d; end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input int w, input string tag, input logic tx, input logic bsy,
                              input logic rdy, input logic [2:0] cnt);
      check({tag, ".uart_tx"},    32'(tx_of(w)),   32'(tx));
      check({tag, ".busy"},       32'(busy_of(w)), 32'(bsy));
      check({tag, ".data_ready"}, 32'(rdy_of(w)),  32'(rdy));
      check({tag, ".fifo_count"}, 32'(cnt_of(w)),  32'(cnt));
   endtask

   // Walks one frame cycle by cycle from cycle index 'skip' (0 = first start-bit cycle);
   // optionally offers byte pd so that it is taken at the edge ending cycle push_at.
   task automatic check_frame(input int w, input logic [7:0] b, input int cpb, input int nstop,
                              input int skip, input int push_at, input logic [7:0] pd,
                              input string tag);
      int   bad [12];
      int   bbad;
      int   nbits;
      int   bi;
      logic e;
      nbits = 9 + nstop;
      bbad  = 0;
      for (int i = 0; i < 12; i++) bad[i] = 0;
      for (int k = skip; k < nbits * cpb; k++) begin
         bi = k / cpb;
         if (bi == 0)      e = 1'b0;
         else if (bi <= 8) e = b[bi-1];
         else              e = 1'b1;
         if (tx_of(w) !== e) bad[bi]++;
         if (busy_of(w) !== 1'b1) bbad++;
         if (k == push_at) drive(w, 1'b1, pd);
         tick();
         if (k == push_at) drive(w, 1'b0, 8'h00);
      end
      for (int i = 0; i < nbits; i++) begin
         check($sformatf("%s.bit%0d_bad_cycles", tag, i), 32'(bad[i]), 32'd0);
      end
      check({tag, ".busy_low_cycles"}, 32'(bbad), 32'd0);
   endtask

   // Line must stay idle and not busy for n cycles.
   task automatic idle_check(input int w, input int n, input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (tx_of(w) !== 1'b1 || busy_of(w) !== 1'b0) bad++;
         tick();
      end
      check({tag, ".idle_bad_cycles"}, 32'(bad), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      drive(0, 1'b1, 8'h5A);
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);

      // Reset holds idle values even with data_valid asserted.
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state(0, $sformatf("rst%0d", i), 1'b1, 1'b0, 1'b1, 3'd0);
      end
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      drive(0, 1'b0, 8'h00);
      idle_check(0, 20, "rst_release");

      // Single byte 0xA5 at the default rate.
      drive(0, 1'b1, 8'hA5);
      tick();
      check_state(0, "a5_accept", 1'b1, 1'b1, 1'b1, 3'd1);
      drive(0, 1'b0, 8'h00);
      tick();
      check_state(0, "a5_pop", 1'b0, 1'b1, 1'b1, 3'd0);
      check_frame(0, 8'hA5, 1250, 1, 0, -1, 8'h00, "a5");
      check_state(0, "a5_done", 1'b1, 1'b0, 1'b1, 3'd0);

      // Burst of six with data_valid held high (CLOCKS_PER_BIT=16).
      drive(1, 1'b1, 8'h00);
      tick();
      check({"burst_e1", ".fifo_count"}, 32'(cnt_b), 32'd1);
      drive(1, 1'b1, 8'hFF);
      tick();
      check_state(1, "burst_e2", 1'b0, 1'b1, 1'b1, 3'd1);
      drive(1, 1'b1, 8'h55);
      tick();
      drive(1, 1'b1, 8'h01);
      tick();
      drive(1, 1'b1, 8'h80);
      tick();
      check_state(1, "burst_full", 1'b0, 1'b1, 1'b0, 3'd4);
      drive(1, 1'b1, 8'h7E);
      check_frame(1, 8'h00, 16, 1, 3, -1, 8'h00, "burst0");
      check_state(1, "burst_refill", 1'b0, 1'b1, 1'b1, 3'd3);
      tick();
      check_state(1, "burst_sixth", 1'b0, 1'b1, 1'b0, 3'd4);
      drive(1, 1'b0, 8'h00);
      check_frame(1, 8'hFF, 16, 1, 1, -1, 8'h00, "burst1");
      check_frame(1, 8'h55, 16, 1, 0, -1, 8'h00, "burst2");
      check_frame(1, 8'h01, 16, 1, 0, -1, 8'h00, "burst3");
      check_frame(1, 8'h80, 16, 1, 0, -1, 8'h00, "burst4");
      check_frame(1, 8'h7E, 16, 1, 0, -1, 8'h00, "burst5");
      check_state(1, "burst_done", 1'b1, 1'b0, 1'b1, 3'd0);

      // Reset during data bit 3 of 0x3C with two bytes queued.
      drive(1, 1'b1, 8'h3C);
      tick();
      drive(1, 1'b1, 8'h11);
      tick();
      check_state(1, "rmf_start", 1'b0, 1'b1, 1'b1, 3'd1);
      drive(1, 1'b1, 8'h22);
      tick();
      drive(1, 1'b0, 8'h00);
      check({"rmf_queued", ".fifo_count"}, 32'(cnt_b), 32'd2);
      for (int i = 0; i < 69; i++) tick();
      check({"rmf_bit3", ".uart_tx"}, 32'(tx_b), 32'd1);
      rst_b = 1'b1;
      #1;
      check_state(1, "rmf_async", 1'b1, 1'b0, 1'b1, 3'd0);
      tick();
      tick();
      rst_b = 1'b0;
      idle_check(1, 40, "rmf_release");
      drive(1, 1'b1, 8'h81);
      tick();
      drive(1, 1'b0, 8'h00);
      tick();
      check_state(1, "rmf_81_pop", 1'b0, 1'b1, 1'b1, 3'd0);
      check_frame(1, 8'h81, 16, 1, 0, -1, 8'h00, "rmf_81");
      idle_check(1, 40, "rmf_after");

      // Push coinciding with the end-of-stop pop while two bytes are queued.
      drive(1, 1'b1, 8'hC3);
      tick();
      drive(1, 1'b1, 8'h5A);
      tick();
      drive(1, 1'b1, 8'h96);
      tick();
      drive(1, 1'b0, 8'h00);
      check_state(1, "pp_queued", 1'b0, 1'b1, 1'b1, 3'd2);
      check_frame(1, 8'hC3, 16, 1, 1, 159, 8'h0F, "pp0");
      check_state(1, "pp_same", 1'b0, 1'b1, 1'b1, 3'd2);
      check_frame(1, 8'h5A, 16, 1, 0, -1, 8'h00, "pp1");
      check_frame(1, 8'h96, 16, 1, 0, -1, 8'h00, "pp2");
      check_frame(1, 8'h0F, 16, 1, 0, -1, 8'h00, "pp3");
      check_state(1, "pp_done", 1'b1, 1'b0, 1'b1, 3'd0);

      // Fast configuration: 4 clocks per bit, two stop bits.
      drive(2, 1'b1, 8'h00);
      tick();
      check({"fast_accept", ".fifo_count"}, 32'(cnt_c), 32'd1);
      drive(2, 1'b0, 8'h00);
      tick();
      check({"fast_pop", ".uart_tx"}, 32'(tx_c), 32'd0);
      check_frame(2, 8'h00, 4, 2, 0, -1, 8'h00, "fast0");
      check_state(2, "fast0_done", 1'b1, 1'b0, 1'b1, 3'd0);
      idle_check(2, 10, "fast_idle");
      drive(2, 1'b1, 8'h00);
      tick();
      drive(2, 1'b0, 8'h00);
      tick();
      check_frame(2, 8'h00, 4, 2, 0, 38, 8'hB7, "fast1");
      check_state(2, "fast_b2b", 1'b0, 1'b1, 1'b1, 3'd0);
      check_frame(2, 8'hB7, 4, 2, 0, -1, 8'h00, "fast2");
      check_state(2, "fast_done", 1'b1, 1'b0, 1'b1, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
